// File: rtl/stall_perf_counters.sv
// ---------------------------------------------------------------------------
// stall_perf_counters : free-running cycle counter plus saturating stall stats
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stall_perf_counters #(
  parameter int CNT_W = 32,
  parameter int RUN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        stall,
  input  logic        robFull,
  input  logic        brnchFull,
  input  logic        aluFull,
  input  logic        mulDivFull,
  input  logic        lwFull,
  input  logic        swFull,
  input  logic [3:0]  rd_sel,
  output logic [63:0] rd_data,
  output logic [63:0] cycle_count,
  output logic        any_stall
);

  localparam int NCAUSE = 7;

  logic [6:0]       causes;
  logic [63:0]      cycle_count_q, cycle_count_d;
  logic             prev_stall_q, prev_stall_d;
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] stall_evt_q, stall_evt_d;
  logic [CNT_W-1:0] cause_q [NCAUSE];
  logic [CNT_W-1:0] cause_d [NCAUSE];
  logic [RUN_W-1:0] cur_run_q, cur_run_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic [RUN_W-1:0] run_inc;
  logic [63:0]      rd_data_q, rd_data_d;

  // Bit i maps to read select i+2.
  assign causes    = {swFull, lwFull, mulDivFull, aluFull, brnchFull, robFull, stall};
  assign any_stall = |causes;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  assign run_inc = sat_run(cur_run_q);

  always_comb begin
    cycle_count_d = cycle_count_q + 64'd1;
    prev_stall_d  = any_stall;
    stall_cyc_d   = stall_cyc_q;
    stall_evt_d   = stall_evt_q;
    cur_run_d     = cur_run_q;
    max_run_d     = max_run_q;
    for (int i = 0; i < NCAUSE; i++) cause_d[i] = cause_q[i];

    if (clear) begin
      stall_cyc_d = '0;
      stall_evt_d = '0;
      cur_run_d   = '0;
      max_run_d   = '0;
      for (int i = 0; i < NCAUSE; i++) cause_d[i] = '0;
    end else if (enable) begin
      for (int i = 0; i < NCAUSE; i++)
        if (causes[i]) cause_d[i] = sat_cnt(cause_q[i]);
      if (any_stall) begin
        stall_cyc_d = sat_cnt(stall_cyc_q);
        cur_run_d   = run_inc;
        if (run_inc > max_run_q) max_run_d = run_inc;
        // A stall already running before this cycle is not a new event.
        if (!prev_stall_q) stall_evt_d = sat_cnt(stall_evt_q);
      end else begin
        cur_run_d = '0;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    case (rd_sel)
      4'd0:  rd_data_d              = cycle_count_q;
      4'd1:  rd_data_d[CNT_W-1:0]   = stall_cyc_q;
      4'd2:  rd_data_d[CNT_W-1:0]   = cause_q[0];
      4'd3:  rd_data_d[CNT_W-1:0]   = cause_q[1];
      4'd4:  rd_data_d[CNT_W-1:0]   = cause_q[2];
      4'd5:  rd_data_d[CNT_W-1:0]   = cause_q[3];
      4'd6:  rd_data_d[CNT_W-1:0]   = cause_q[4];
      4'd7:  rd_data_d[CNT_W-1:0]   = cause_q[5];
      4'd8:  rd_data_d[CNT_W-1:0]   = cause_q[6];
      4'd9:  rd_data_d[CNT_W-1:0]   = stall_evt_q;
      4'd10: rd_data_d[RUN_W-1:0]   = cur_run_q;
      4'd11: rd_data_d[RUN_W-1:0]   = max_run_q;
      default: rd_data_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      prev_stall_q  <= 1'b0;
      stall_cyc_q   <= '0;
      stall_evt_q   <= '0;
      cur_run_q     <= '0;
      max_run_q     <= '0;
      rd_data_q     <= '0;
      for (int i = 0; i < NCAUSE; i++) cause_q[i] <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      prev_stall_q  <= prev_stall_d;
      stall_cyc_q   <= stall_cyc_d;
      stall_evt_q   <= stall_evt_d;
      cur_run_q     <= cur_run_d;
      max_run_q     <= max_run_d;
      rd_data_q     <= rd_data_d;
      for (int i = 0; i < NCAUSE; i++) cause_q[i] <= cause_d[i];
    end
  end

  assign cycle_count = cycle_count_q;
  assign rd_data     = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_stall_perf_counters.sv
// ---------------------------------------------------------------------------
// tb_stall_perf_counters : directed self-checking bench for stall_perf_counters
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stall_perf_counters;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, clear;
  logic        st, rob, brn, alu, md, lw, sw;
  logic [3:0]  rd_sel;
  logic [63:0] rd_data, cycle_count;
  logic        any_stall;

  logic        b_enable, b_alu, zero;
  logic [3:0]  b_rd_sel;
  logic [63:0] b_rd_data, b_cycle_count;
  logic        b_any_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stall_perf_counters #(.CNT_W(32), .RUN_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .stall(st), .robFull(rob), .brnchFull(brn), .aluFull(alu),
    .mulDivFull(md), .lwFull(lw), .swFull(sw),
    .rd_sel(rd_sel), .rd_data(rd_data), .cycle_count(cycle_count),
    .any_stall(any_stall)
  );

  stall_perf_counters #(.CNT_W(4), .RUN_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .clear(zero),
    .stall(zero), .robFull(zero), .brnchFull(zero), .aluFull(b_alu),
    .mulDivFull(zero), .lwFull(zero), .swFull(zero),
    .rd_sel(b_rd_sel), .rd_data(b_rd_data), .cycle_count(b_cycle_count),
    .any_stall(b_any_stall)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Select a counter while the stats are idle; rd_data shows it one edge later.
  task automatic read_a(input logic [3:0] sel, input string tag, input logic [63:0] exp);
    rd_sel = sel;
    @(negedge clk);
    check_value(tag, rd_data, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [63:0] snap;
  logic [7:0]  pat;

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    st = 0; rob = 0; brn = 0; alu = 0; md = 0; lw = 0; sw = 0;
    rd_sel = 4'd0; b_enable = 1'b0; b_alu = 1'b0; zero = 1'b0; b_rd_sel = 4'd0;

    @(negedge clk);
    check_value("reset_cycle_count", cycle_count, 64'd0);
    check_value("reset_rd_data", rd_data, 64'd0);
    check_value("idle_any_stall", {63'd0, any_stall}, 64'd0);

    rst_n = 1'b1;
    idle(10);
    check_value("cycle_count_10", cycle_count, 64'd10);
    read_a(4'd1, "idle_stall_cyc", 64'd0);
    read_a(4'd12, "sel12_zero", 64'd0);

    // rob+lw stall for five cycles
    enable = 1'b1; rob = 1'b1; lw = 1'b1;
    #1 check_value("any_stall_comb", {63'd0, any_stall}, 64'd1);
    idle(5);
    rob = 1'b0; lw = 1'b0;
    read_a(4'd1,  "t2_stall_cyc", 64'd5);
    read_a(4'd3,  "t2_rob",       64'd5);
    read_a(4'd7,  "t2_lw",        64'd5);
    read_a(4'd5,  "t2_alu",       64'd0);
    read_a(4'd9,  "t2_evt",       64'd1);
    read_a(4'd11, "t2_max_run",   64'd5);
    read_a(4'd10, "t2_cur_run",   64'd0);

    // run-length pattern 1,1,0,1,0,1,1,1
    clear = 1'b1; idle(1); clear = 1'b0;
    pat = 8'b1110_1011;
    for (int i = 0; i < 8; i++) begin
      st = pat[i];
      idle(1);
    end
    st = 1'b0;
    read_a(4'd9,  "t3_evt",       64'd3);
    read_a(4'd1,  "t3_stall_cyc", 64'd6);
    read_a(4'd2,  "t3_stall",     64'd6);
    read_a(4'd11, "t3_max_run",   64'd3);

    // narrow counter saturates while cycle_count keeps going
    b_enable = 1'b1; b_alu = 1'b1;
    snap = b_cycle_count;
    idle(20);
    check_value("b_cycle_count_runs", b_cycle_count, snap + 64'd20);
    b_rd_sel = 4'd5;
    idle(1);
    check_value("b_alu_sat", b_rd_data, 64'd15);
    idle(3);
    check_value("b_alu_hold", b_rd_data, 64'd15);
    b_rd_sel = 4'd1;
    idle(1);
    check_value("b_stall_cyc_sat", b_rd_data, 64'd15);
    b_alu = 1'b0; b_enable = 1'b0;

    // stall already active when enable rises is not an event
    clear = 1'b1; idle(1); clear = 1'b0;
    enable = 1'b0; md = 1'b1;
    idle(3);
    enable = 1'b1;
    idle(4);
    md = 1'b0;
    read_a(4'd9,  "t5_evt",       64'd0);
    read_a(4'd1,  "t5_stall_cyc", 64'd4);
    read_a(4'd6,  "t5_muldiv",    64'd4);

    // clear during a stall wins and leaves cycle_count alone
    md = 1'b1; clear = 1'b1;
    snap = cycle_count;
    idle(1);
    md = 1'b0; clear = 1'b0;
    check_value("clear_keeps_cycle", cycle_count, snap + 64'd1);
    read_a(4'd1, "t5_clear_stall_cyc", 64'd0);
    read_a(4'd6, "t5_clear_muldiv",    64'd0);

    rd_sel = 4'd0;
    snap = cycle_count;
    idle(1);
    check_value("sel0_cycle_count", rd_data, snap);
    read_a(4'd13, "sel13_zero", 64'd0);

    // wrap of the 64-bit cycle counter
    force dut_a.cycle_count_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut_a.cycle_count_q;
    #1 check_value("wrap_preload", cycle_count, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(1);
    check_value("wrap_max", cycle_count, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    check_value("wrap_zero", cycle_count, 64'd0);
    idle(1);
    check_value("wrap_one", cycle_count, 64'd1);

    // asynchronous reset in the middle of a cycle
    rob = 1'b1; rd_sel = 4'd0;
    idle(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0; rob = 1'b0;
    #1;
    check_value("async_cycle_count", cycle_count, 64'd0);
    check_value("async_rd_data", rd_data, 64'd0);
    check_value("async_any_stall", {63'd0, any_stall}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_a(4'd3, "after_reset_rob", 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stall_perf_counters.md
# stall_perf_counters

Free-running cycle counter and stall-statistics block for the pipeline. It sits directly upstream of the stall trace monitor and drives its 64-bit `cycle_count` input. It observes the same seven stall/full signals the monitor prints and accumulates per-cause cycle counts, stall-event counts and stall run lengths. A registered read port exposes all counters to the debug/CSR path.

## Interface
- `CNT_W`, 32: width of the per-cause and aggregate stall counters (1..64)
- `RUN_W`, 16: width of the current and maximum stall-run counters (1..64)

- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  statistics counting enable; does not gate `cycle_count`
- `clear`  in  1  synchronous clear of all statistics counters
- `stall`, `robFull`, `brnchFull`, `aluFull`, `mulDivFull`, `lwFull`, `swFull`  in  1 each  stall causes, same signals as the trace monitor
- `rd_sel`  in  4  counter select
- `rd_data`  out  64  selected counter, zero-extended, registered
- `cycle_count`  out  64  free-running cycle number, drives the trace monitor
- `any_stall`  out  1  combinational OR of the seven causes

## Operation
- Reset: every register is cleared to 0, including `cycle_count`, `rd_data`, all counters and `prev_stall`.
- `cycle_count`: increments by 1 on every edge while out of reset. It ignores `enable` and `clear`. It wraps from 2^64-1 to 0.
- `any_stall = stall|robFull|brnchFull|aluFull|mulDivFull|lwFull|swFull`.
- Statistics registers, all updated only when `enable=1`:
  - `stall_cyc`: +1 per cycle with `any_stall`.
  - Seven cause counters: each +1 per cycle its input is high. Several causes can count in the same cycle.
  - `stall_evt`: +1 on each 0→1 transition of `any_stall`, using `prev_stall`.
  - `cur_run`: +1 on a stall cycle, loads 0 on a non-stall cycle.
  - `max_run`: loads `cur_run+1` when that value exceeds `max_run` on a stall cycle.
- Arithmetic: all statistics counters saturate at their all-ones value and never wrap. `max_run` compares against the saturated `cur_run+1`.
- `prev_stall` loads `any_stall` every cycle regardless of `enable`, so a stall already in progress when `enable` rises is not counted as an event.
- `enable=0`: all statistics registers hold.
- `clear=1`: zeroes every statistics register on that edge. Clear has priority over increment, so that cycle's activity is lost. `prev_stall` still loads `any_stall`. `cycle_count` is unaffected.
- Read map (`rd_sel`):
  - 0 `cycle_count`
  - 1 `stall_cyc`
  - 2 `stall`
  - 3 `robFull`
  - 4 `brnchFull`
  - 5 `aluFull`
  - 6 `mulDivFull`
  - 7 `lwFull`
  - 8 `swFull`
  - 9 `stall_evt`
  - 10 `cur_run`
  - 11 `max_run`
  - 12–15 return 0

## Timing
- `cycle_count` is 0 during reset. The first rising edge after `rst_n` deasserts makes it 1. The trace monitor samples the pre-edge value, so a stall in the first cycle after reset is logged as cycle 0.
- Counter update latency is 1 edge: a stall present in cycle N is visible in the counter registers from cycle N+1.
- `rd_data` has 1-cycle latency: `rd_data` in cycle N+1 equals the register selected by `rd_sel` in cycle N, excluding cycle N's increment.
- `rst_n` assertion mid-run clears everything immediately (asynchronously). Deassertion is assumed synchronised externally.
- `any_stall` is purely combinational with no added latency.

## Test plan
- Reset release, no stalls, 10 edges → `cycle_count`=10, `rd_sel`=1 reads 0, `rd_sel`=12 reads 0.
- `enable`=1, `robFull`=1 and `lwFull`=1 for 5 cycles, then idle → `stall_cyc`=5, rob=5, lw=5, `stall_evt`=1, `max_run`=5, `cur_run`=0.
- Stall pattern 1,1,0,1,0,1,1,1 → `stall_evt`=3, `stall_cyc`=6, `max_run`=3.
- `CNT_W`=4, `aluFull` high 20 cycles → alu counter reads 15 and holds; `cycle_count` keeps incrementing.
- Stall high while `enable`=0, `enable` rises mid-stall for 4 cycles → `stall_evt`=0, `stall_cyc`=4. Assert `clear` during a stall cycle → next read of `stall_cyc`=0 and `cycle_count` is not reset.
- Preload `cycle_count` to 2^64-2 by force, run 3 edges → values 2^64-1, 0, 1. Assert `rst_n` low mid-run → all outputs 0 without waiting for a clock edge.
